// File: rtl/iob_axi_ram_arbiter_pkg.sv
// Shared types and helpers for the AXI RAM arbiter.
// Build option: IOB_AXI_RAM_ARBITER_RR_EN selects round-robin arbitration;
// when it is undefined, arbitration is fixed priority with the lowest index winning.
package iob_axi_ram_arbiter_pkg;

    // Transaction sequencer states: pick a requester, issue address/data,
    // wait for the response, then pulse the completion handshake.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEFAULT_N_REQ = 2;

    // Width of a requester index. It never drops below one bit, so that
    // index registers stay legal vectors.
    function automatic int gnt_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam int DEFAULT_GNT_W = $clog2(DEFAULT_N_REQ);

endpackage

// File: rtl/iob_axi_ram_arbiter_sel.sv
// Combinational grant selection: one-hot grant plus encoded index.
// Build option: IOB_AXI_RAM_ARBITER_RR_EN adds the ptr input and a rotating
// search that starts at ptr; without it the lowest valid index wins.
module iob_axi_ram_arbiter_sel
    import iob_axi_ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int GNT_W = gnt_width(N_REQ)
) (
`ifdef IOB_AXI_RAM_ARBITER_RR_EN
    input  logic [GNT_W-1:0] ptr,
`endif
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [GNT_W-1:0] gnt_idx,
    output logic             gnt_any
);

`ifdef IOB_AXI_RAM_ARBITER_RR_EN

    // ptr is always below N_REQ, so one conditional subtract wraps the sum
    function automatic logic [GNT_W-1:0] wrap_add(input logic [GNT_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return GNT_W'(sum);
    endfunction

    // Rotating search: the first valid requester at or after ptr wins
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[wrap_add(ptr, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_add(ptr, i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rr_onehot
            assign gnt_onehot[gi] = gnt_any && (gnt_idx == GNT_W'(gi));
        end
    endgenerate

`else

    // Fixed priority: a requester wins only if no lower index is valid
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fp_onehot
            if (gi == 0) begin : g_first
                assign gnt_onehot[gi] = req_valid[gi];
            end else begin : g_rest
                assign gnt_onehot[gi] = req_valid[gi] && !(|req_valid[gi-1:0]);
            end
        end
    endgenerate

    assign gnt_any = |req_valid;

    // Encode the lowest valid index by scanning from the top down
    always_comb begin
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_idx = GNT_W'(i);
            end
        end
    end

`endif

endmodule

// File: rtl/iob_axi_ram_arbiter.sv
// Shares one AXI4 RAM slave port among N_REQ native requesters, one
// single-beat transaction at a time. Every output comes straight from a register.
// Build option: IOB_AXI_RAM_ARBITER_RR_EN enables round-robin arbitration
// and its priority pointer; the default build uses fixed priority.
module iob_axi_ram_arbiter
    import iob_axi_ram_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
    input  logic [N_REQ*STRB_W-1:0]  req_wstrb_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_rdata_o,
    output logic [ADDR_W-1:0]        axi_awaddr_o,
    output logic                     axi_awvalid_o,
    input  logic                     axi_awready_i,
    output logic [DATA_W-1:0]        axi_wdata_o,
    output logic [STRB_W-1:0]        axi_wstrb_o,
    output logic                     axi_wvalid_o,
    input  logic                     axi_wready_i,
    input  logic                     axi_bvalid_i,
    output logic                     axi_bready_o,
    output logic [ADDR_W-1:0]        axi_araddr_o,
    output logic                     axi_arvalid_o,
    input  logic                     axi_arready_i,
    input  logic [DATA_W-1:0]        axi_rdata_i,
    input  logic                     axi_rvalid_i,
    output logic                     axi_rready_o
);

    localparam int GNT_W = gnt_width(N_REQ);

    state_t              state_reg, state_next;
    logic [GNT_W-1:0]    gnt_idx_reg, gnt_idx_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic                is_write_reg, is_write_next;
    logic                awvalid_reg, awvalid_next;
    logic                wvalid_reg, wvalid_next;
    logic                arvalid_reg, arvalid_next;
    logic                bready_reg, bready_next;
    logic                rready_reg, rready_next;
    logic [N_REQ-1:0]    req_ready_reg, req_ready_next;
    logic [N_REQ-1:0]    rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;

    logic [N_REQ-1:0]    sel_onehot;
    logic [GNT_W-1:0]    sel_idx;
    logic                sel_any;

    logic [ADDR_W-1:0]   addr_masked  [N_REQ];
    logic [DATA_W-1:0]   wdata_masked [N_REQ];
    logic [STRB_W-1:0]   wstrb_masked [N_REQ];
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [STRB_W-1:0]   sel_wstrb;

`ifdef IOB_AXI_RAM_ARBITER_RR_EN
    logic [GNT_W-1:0]    ptr_reg, ptr_next;
`endif

    iob_axi_ram_arbiter_sel #(
        .N_REQ (N_REQ),
        .GNT_W (GNT_W)
    ) u_sel (
`ifdef IOB_AXI_RAM_ARBITER_RR_EN
        .ptr        (ptr_reg),
`endif
        .req_valid  (req_valid_i),
        .gnt_onehot (sel_onehot),
        .gnt_idx    (sel_idx),
        .gnt_any    (sel_any)
    );

    // Gate each requester's fields with its grant bit so a plain OR picks the winner
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_mux
            assign addr_masked[gi]  = sel_onehot[gi] ? req_addr_i[gi*ADDR_W +: ADDR_W]  : '0;
            assign wdata_masked[gi] = sel_onehot[gi] ? req_wdata_i[gi*DATA_W +: DATA_W] : '0;
            assign wstrb_masked[gi] = sel_onehot[gi] ? req_wstrb_i[gi*STRB_W +: STRB_W] : '0;
        end
    endgenerate

    // OR-reduce the gated request fields into the granted request
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_addr  = sel_addr  | addr_masked[i];
            sel_wdata = sel_wdata | wdata_masked[i];
            sel_wstrb = sel_wstrb | wstrb_masked[i];
        end
    end

    // Next-state and next-output logic of the transaction sequencer
    always_comb begin
        state_next     = state_reg;
        gnt_idx_next   = gnt_idx_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wstrb_next     = wstrb_reg;
        is_write_next  = is_write_reg;
        awvalid_next   = awvalid_reg;
        wvalid_next    = wvalid_reg;
        arvalid_next   = arvalid_reg;
        bready_next    = bready_reg;
        rready_next    = rready_reg;
        rdata_next     = rdata_reg;
        req_ready_next = '0;
        rsp_valid_next = '0;

        unique case (state_reg)
            ST_IDLE: begin
                if (sel_any) begin
                    gnt_idx_next  = sel_idx;
                    addr_next     = sel_addr;
                    wdata_next    = sel_wdata;
                    wstrb_next    = sel_wstrb;
                    is_write_next = |sel_wstrb;
                    awvalid_next  = |sel_wstrb;
                    wvalid_next   = |sel_wstrb;
                    arvalid_next  = ~(|sel_wstrb);
                    state_next    = ST_ADDR;
                end
            end

            ST_ADDR: begin
                // Each channel drops on its own handshake; AW and W may finish in any order
                awvalid_next = awvalid_reg && !axi_awready_i;
                wvalid_next  = wvalid_reg  && !axi_wready_i;
                arvalid_next = arvalid_reg && !axi_arready_i;
                if (!(awvalid_next || wvalid_next || arvalid_next)) begin
                    bready_next = is_write_reg;
                    rready_next = !is_write_reg;
                    state_next  = ST_RESP;
                end
            end

            ST_RESP: begin
                if (is_write_reg ? (axi_bvalid_i && bready_reg)
                                 : (axi_rvalid_i && rready_reg)) begin
                    bready_next = 1'b0;
                    rready_next = 1'b0;
                    if (!is_write_reg) begin
                        rdata_next = axi_rdata_i;
                    end
                    for (int i = 0; i < N_REQ; i++) begin
                        req_ready_next[i] = (gnt_idx_reg == GNT_W'(i));
                        rsp_valid_next[i] = !is_write_reg && (gnt_idx_reg == GNT_W'(i));
                    end
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                // The completion pulses clear through their defaults
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            gnt_idx_reg   <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            is_write_reg  <= 1'b0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            bready_reg    <= 1'b0;
            rready_reg    <= 1'b0;
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_idx_reg   <= gnt_idx_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            is_write_reg  <= is_write_next;
            awvalid_reg   <= awvalid_next;
            wvalid_reg    <= wvalid_next;
            arvalid_reg   <= arvalid_next;
            bready_reg    <= bready_next;
            rready_reg    <= rready_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
        end
    end

`ifdef IOB_AXI_RAM_ARBITER_RR_EN
    // Once a transaction completes, the search restarts just past the last grant
    always_comb begin
        ptr_next = ptr_reg;
        if (state_reg == ST_DONE) begin
            ptr_next = (int'(gnt_idx_reg) == N_REQ - 1) ? '0 : gnt_idx_reg + 1'b1;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`endif

    assign req_ready_o   = req_ready_reg;
    assign rsp_valid_o   = rsp_valid_reg;
    assign rsp_rdata_o   = rdata_reg;
    assign axi_awaddr_o  = addr_reg;
    assign axi_araddr_o  = addr_reg;
    assign axi_wdata_o   = wdata_reg;
    assign axi_wstrb_o   = wstrb_reg;
    assign axi_awvalid_o = awvalid_reg;
    assign axi_wvalid_o  = wvalid_reg;
    assign axi_arvalid_o = arvalid_reg;
    assign axi_bready_o  = bready_reg;
    assign axi_rready_o  = rready_reg;

endmodule

// File: tb/tb_iob_axi_ram_arbiter.sv
// Self-checking bench for iob_axi_ram_arbiter: directed table, hand-written
// corner sequences and randomized rounds against a word-level reference model.
// Honours IOB_AXI_RAM_ARBITER_RR_EN for the expected arbitration order.
module tb_iob_axi_ram_arbiter;

    localparam int N_REQ  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int STRB_W = 4;
`ifdef IOB_AXI_RAM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ*STRB_W-1:0] req_wstrb;
    logic [N_REQ-1:0]        req_ready_o, rsp_valid_o;
    logic [DATA_W-1:0]       rsp_rdata_o;
    logic [ADDR_W-1:0]       axi_awaddr_o, axi_araddr_o;
    logic                    axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o;
    logic [DATA_W-1:0]       axi_wdata_o;
    logic [STRB_W-1:0]       axi_wstrb_o;
    logic                    awready, wready, bvalid, arready, rvalid;
    logic [DATA_W-1:0]       rdata_s;

    iob_axi_ram_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STRB_W(STRB_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(awready),
        .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(wready),
        .axi_bvalid_i(bvalid), .axi_bready_o(axi_bready_o),
        .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(arready),
        .axi_rdata_i(rdata_s), .axi_rvalid_i(rvalid), .axi_rready_o(axi_rready_o)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- AXI RAM slave model (acts on falling edges) ----------------
    logic [31:0] ram [0:16383];
    int aw_stall = 0, w_stall = 0, ar_stall = 0, b_stall = 0, r_stall = 0;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit got_aw, got_w, got_ar, b_done, r_done;
    logic [15:0] aw_addr_l, ar_addr_l;
    logic [31:0] wdata_l;
    logic [3:0]  wstrb_l;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata_s = '0;
            got_aw = 0; got_w = 0; got_ar = 0; b_done = 0; r_done = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            // write response
            if (b_done) begin
                bvalid = 0; b_done = 0;
            end else if (bvalid) begin
                if (axi_bready_o) b_done = 1;
            end else if (got_aw && got_w) begin
                if (b_cnt == 0) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb_l[b]) ram[aw_addr_l[15:2]][8*b +: 8] = wdata_l[8*b +: 8];
                end
                if (b_cnt >= b_stall) begin
                    bvalid = 1; got_aw = 0; got_w = 0; b_cnt = 0;
                    if (axi_bready_o) b_done = 1;
                end else b_cnt++;
            end
            // read data (garbage on the bus whenever rvalid is low)
            if (r_done) begin
                rvalid = 0; r_done = 0; rdata_s = $urandom;
            end else if (rvalid) begin
                if (axi_rready_o) r_done = 1;
            end else if (got_ar) begin
                if (r_cnt >= r_stall) begin
                    rvalid = 1; rdata_s = ram[ar_addr_l[15:2]]; got_ar = 0; r_cnt = 0;
                    if (axi_rready_o) r_done = 1;
                end else begin
                    r_cnt++; rdata_s = $urandom;
                end
            end else rdata_s = $urandom;
            // address / data acceptance with programmable stalls
            awready = axi_awvalid_o && (aw_cnt >= aw_stall);
            if (awready) begin got_aw = 1; aw_addr_l = axi_awaddr_o; end
            else if (axi_awvalid_o) aw_cnt++; else aw_cnt = 0;
            wready = axi_wvalid_o && (w_cnt >= w_stall);
            if (wready) begin got_w = 1; wdata_l = axi_wdata_o; wstrb_l = axi_wstrb_o; end
            else if (axi_wvalid_o) w_cnt++; else w_cnt = 0;
            arready = axi_arvalid_o && (ar_cnt >= ar_stall);
            if (arready) begin got_ar = 1; ar_addr_l = axi_araddr_o; end
            else if (axi_arvalid_o) ar_cnt++; else ar_cnt = 0;
        end
    end

    // ---------------- channel monitor ----------------
    int mon_cyc, aw_hi, w_hi, last_aw, first_b, ready_cnt;
    always @(negedge clk) begin
        mon_cyc++;
        if (axi_awvalid_o) begin aw_hi++; last_aw = mon_cyc; end
        if (axi_wvalid_o) w_hi++;
        if (axi_bready_o && first_b < 0) first_b = mon_cyc;
        if (req_ready_o != '0) ready_cnt++;
        if (!rst && ($countones(req_ready_o) > 1 || (rsp_valid_o & ~req_ready_o) != '0)) begin
            bad++;
            $display("FAIL pulse_shape: req_ready=%b rsp_valid=%b, required one-hot ready covering rsp_valid",
                     req_ready_o, rsp_valid_o);
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:63];
    int ptr_model = 0;
    logic [ADDR_W-1:0] p_addr  [N_REQ];
    logic [DATA_W-1:0] p_wdata [N_REQ];
    logic [STRB_W-1:0] p_wstrb [N_REQ];

    function automatic logic [N_REQ-1:0] oh(input int idx);
        logic [N_REQ-1:0] r;
        r = '0;
        if (idx >= 0 && idx < N_REQ) r[idx] = 1'b1;
        return r;
    endfunction

    // round-robin: first pending requester counting up from ptr; fixed: from 0
    function automatic int model_pick(input logic [N_REQ-1:0] pend, input int ptr);
        int start, k;
        start = RR ? ptr : 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (start + i) % N_REQ;
            if (pend[k]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready_o), 0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata_o), 0);
        chk({tag, "_valids"}, {61'd0, axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 0);
        chk({tag, "_readies"}, {62'd0, axi_bready_o, axi_rready_o}, 0);
        chk({tag, "_addr"}, {axi_awaddr_o, axi_araddr_o}, 0);
        chk({tag, "_wdata_strb"}, {axi_wdata_o, axi_wstrb_o}, 0);
    endtask

    task automatic drive_bus();
        for (int k = 0; k < N_REQ; k++) begin
            req_addr[k*ADDR_W +: ADDR_W]  = p_addr[k];
            req_wdata[k*DATA_W +: DATA_W] = p_wdata[k];
            req_wstrb[k*STRB_W +: STRB_W] = p_wstrb[k];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        ptr_model = 0;
    endtask

    // Present the requests in mask together and serve them until every one has completed
    task automatic serve(input logic [N_REQ-1:0] mask, output int first_lat, output logic [31:0] last_rdata);
        logic [N_REQ-1:0] pending;
        int cyc, g;
        pending = mask; first_lat = -1; last_rdata = '0; cyc = 0;
        @(negedge clk);
        drive_bus();
        req_valid = mask;
        while (pending != '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req_ready_o != '0) begin
                g = model_pick(pending, ptr_model);
                chk("grant", 64'(req_ready_o), 64'(oh(g)));
                if (g < 0) break;
                if (p_wstrb[g] == '0) begin
                    chk("rsp_valid_rd", 64'(rsp_valid_o), 64'(oh(g)));
                    chk("rdata", 64'(rsp_rdata_o), 64'(ref_mem[p_addr[g][7:2]]));
                    last_rdata = rsp_rdata_o;
                end else begin
                    chk("rsp_valid_wr", 64'(rsp_valid_o), 0);
                    for (int b = 0; b < 4; b++)
                        if (p_wstrb[g][b]) ref_mem[p_addr[g][7:2]][8*b +: 8] = p_wdata[g][8*b +: 8];
                end
                $display("txn req=%0d %s addr=0x%h wdata=0x%h wstrb=%b rdata=0x%h cycles=%0d",
                         g, (p_wstrb[g] == '0) ? "RD" : "WR", p_addr[g], p_wdata[g], p_wstrb[g],
                         rsp_rdata_o, cyc);
                pending[g] = 1'b0;
                req_valid[g] = 1'b0;
                ptr_model = (g + 1) % N_REQ;
                if (first_lat < 0) first_lat = cyc;
            end
        end
        if (pending != '0) begin
            total++; bad++;
            $display("FAIL serve_timeout: pending=%b after %0d cycles, required none pending", pending, cyc);
            req_valid = '0;
        end
    endtask

    typedef struct {
        int          req;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [4];
    int   exp_seq [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, cyc, g, last;
        logic [31:0] rd;

        vecs[0] = '{0, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2] = '{1, 16'h0010, 32'h00001234, 4'h3, 32'h0};
        vecs[3] = '{1, 16'h0010, 32'h0,        4'h0, 32'hDEAD1234};
        if (RR) exp_seq = '{0, 1, 0, 1};
        else    exp_seq = '{0, 0, 0, 0};

        for (int i = 0; i < 16384; i++) ram[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        for (int k = 0; k < N_REQ; k++) begin p_addr[k] = '0; p_wdata[k] = '0; p_wstrb[k] = '0; end
        req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mon_cyc = 0; aw_hi = 0; w_hi = 0; last_aw = -1; first_b = -1; ready_cnt = 0;

        // reset state
        rst = 1;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 0;
        @(negedge clk);
        chk_all_zero("post_reset");

        // directed table: write, read back, partial strobe, read back (zero-wait RAM)
        for (int i = 0; i < 4; i++) begin
            p_addr[vecs[i].req]  = vecs[i].addr;
            p_wdata[vecs[i].req] = vecs[i].wdata;
            p_wstrb[vecs[i].req] = vecs[i].wstrb;
            serve(oh(vecs[i].req), lat, rd);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 3);
            if (vecs[i].wstrb == '0) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        end

        // backpressure: AW stalled 3 cycles, W accepted at once
        aw_stall = 3;
        @(posedge clk); #1;
        aw_hi = 0; w_hi = 0; last_aw = -1; first_b = -1; ready_cnt = 0; mon_cyc = 0;
        p_addr[0] = 16'h0020; p_wdata[0] = 32'hA5A5_5A5A; p_wstrb[0] = 4'hF;
        serve(oh(0), lat, rd);
        repeat (4) @(negedge clk);
        chk("bp_wvalid_cycles", 64'(w_hi), 1);
        chk("bp_awvalid_cycles", 64'(aw_hi), 4);
        chk("bp_resp_after_aw", 64'(first_b > last_aw), 1);
        chk("bp_ready_pulses", 64'(ready_cnt), 1);
        aw_stall = 0;

        // both requesters held valid continuously for four transactions
        do_reset();
        p_addr[0] = 16'h0010; p_addr[1] = 16'h0010; p_wstrb[0] = '0; p_wstrb[1] = '0;
        @(negedge clk);
        drive_bus();
        req_valid = '1;
        n = 0; cyc = 0; last = 0;
        while (n < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (req_ready_o != '0) begin
                g = (req_ready_o[0]) ? 0 : 1;
                chk($sformatf("cont_grant%0d", n), 64'(g), 64'(exp_seq[n]));
                chk($sformatf("cont_rdata%0d", n), 64'(rsp_rdata_o), 64'h0000_0000_DEAD_1234);
                $display("txn req=%0d RD addr=0x0010 rdata=0x%h cycles=%0d", g, rsp_rdata_o, cyc);
                last = g;
                n++;
            end
        end
        if (n < 4) begin
            total++; bad++;
            $display("FAIL cont_timeout: got %0d grants, required 4", n);
        end
        req_valid = '0;
        ptr_model = (last + 1) % N_REQ;

        // reset while waiting in the response phase of a write
        b_stall = 6;
        p_addr[0] = 16'h0080; p_wdata[0] = 32'h1111_2222; p_wstrb[0] = 4'hF;
        @(negedge clk);
        drive_bus();
        req_valid = 2'b01;
        cyc = 0;
        while (!axi_bready_o && cyc < 30) begin @(negedge clk); cyc++; end
        chk("mid_resp_bready_seen", 64'(axi_bready_o), 1);
        rst = 1;
        #1;
        chk_all_zero("mid_resp_reset");
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 0;
        b_stall = 0;
        ptr_model = 0;
        p_addr[1] = 16'h0010; p_wstrb[1] = '0; p_wdata[1] = '0;
        serve(oh(1), lat, rd);
        chk("after_reset_rdata", 64'(rd), 64'h0000_0000_DEAD_1234);
        chk("after_reset_latency", 64'(lat), 3);

        // randomized rounds: random request sets, data, strobes and RAM stalls
        for (int r = 0; r < 40; r++) begin
            aw_stall = $urandom_range(0, 2); w_stall = $urandom_range(0, 2);
            ar_stall = $urandom_range(0, 2); b_stall = $urandom_range(0, 2);
            r_stall  = $urandom_range(0, 2);
            for (int k = 0; k < N_REQ; k++) begin
                p_addr[k]  = 16'($urandom_range(0, 15) * 4);
                p_wdata[k] = $urandom;
                p_wstrb[k] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            serve(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), lat, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
